// File: rtl/block_issue_sequencer_if.sv
// rtl/block_issue_sequencer_if.sv - block input, instruction output and control signals of the issue sequencer
interface block_issue_sequencer_if #(
  parameter int ID_W = 7
);
  logic [127:0]    block_data_in;
  logic [ID_W-1:0] block_id_in;
  logic            block_valid_in;
  logic            block_ready_out;
  logic            flush_in;
  logic [31:0]     insn_out;
  logic            insn_valid_out;
  logic            insn_ready_in;
  logic [ID_W-1:0] insn_block_id_out;
  logic [1:0]      insn_slot_out;
  logic            insn_last_out;
  logic            block_done_out;
  logic [ID_W-1:0] block_done_id_out;
  logic            busy_out;

  modport master (
    output block_data_in, block_id_in, block_valid_in, flush_in, insn_ready_in,
    input  block_ready_out, insn_out, insn_valid_out, insn_block_id_out,
    input  insn_slot_out, insn_last_out, block_done_out, block_done_id_out, busy_out
  );

  modport slave (
    input  block_data_in, block_id_in, block_valid_in, flush_in, insn_ready_in,
    output block_ready_out, insn_out, insn_valid_out, insn_block_id_out,
    output insn_slot_out, insn_last_out, block_done_out, block_done_id_out, busy_out
  );
endinterface

// File: rtl/block_issue_sequencer.sv
// rtl/block_issue_sequencer.sv - buffers 4-instruction blocks and issues them one word per cycle
// Padding (all-zero) slots are skipped through a per-entry live mask; a done pulse marks each retired block.
module block_issue_sequencer #(
  parameter int ID_W  = 7,
  parameter int DEPTH = 2
) (
  input logic                    clk,
  input logic                    rst,
  block_issue_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [127:0]    data_q [DEPTH];
  logic [ID_W-1:0] id_q   [DEPTH];
  logic [3:0]      mask_q [DEPTH];
  logic [AW:0]     rd_ptr_q, wr_ptr_q;
  logic            done_q;
  logic [ID_W-1:0] done_id_q;

  logic [AW-1:0]   rd_idx, wr_idx;
  logic            empty, full, one_left;
  logic [3:0]      head_mask, slot_oh;
  logic [127:0]    head_data;
  logic [ID_W-1:0] head_id;
  logic [1:0]      slot;
  logic [31:0]     cur_word;
  logic            is_last, issue_valid, fire, retire, push, ready_int;

  always_comb begin
    rd_idx    = rd_ptr_q[AW-1:0];
    wr_idx    = wr_ptr_q[AW-1:0];
    empty     = (rd_ptr_q == wr_ptr_q);
    full      = (rd_idx == wr_idx) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    one_left  = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(1));
    head_mask = mask_q[rd_idx];
    head_data = data_q[rd_idx];
    head_id   = id_q[rd_idx];

    // Lowest live slot is next in program order.
    slot = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (head_mask[k]) slot = 2'(k);
    end
    slot_oh = 4'b0001 << slot;

    case (slot)
      2'd0:    cur_word = head_data[127:96];
      2'd1:    cur_word = head_data[95:64];
      2'd2:    cur_word = head_data[63:32];
      default: cur_word = head_data[31:0];
    endcase

    is_last     = (head_mask != 4'd0) && ((head_mask & (head_mask - 4'd1)) == 4'd0);
    issue_valid = (state_q == ISSUE) && (head_mask != 4'd0);
    fire        = issue_valid && bus.insn_ready_in;
    // An empty-mask head retires without ever issuing.
    retire      = (state_q == ISSUE) && ((head_mask == 4'd0) || (fire && is_last));
    ready_int   = !full && !bus.flush_in;
    push        = bus.block_valid_in && ready_int;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = ISSUE;
      ISSUE:   if (retire && one_left && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush_in) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_in) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      done_q    <= 1'b0;
      done_id_q <= rst ? '0 : done_id_q;
    end else begin
      done_q <= retire;
      if (retire) begin
        done_id_q <= head_id;
        rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
    end
  end

  // Payload storage needs no reset: entries are only read while the FIFO holds them.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush_in) begin
      if (fire && !is_last) mask_q[rd_idx] <= head_mask & ~slot_oh;
      if (push) begin
        data_q[wr_idx] <= bus.block_data_in;
        id_q[wr_idx]   <= bus.block_id_in;
        mask_q[wr_idx] <= {bus.block_data_in[31:0]   != 32'h0,
                           bus.block_data_in[63:32]  != 32'h0,
                           bus.block_data_in[95:64]  != 32'h0,
                           bus.block_data_in[127:96] != 32'h0};
      end
    end
  end

  assign bus.block_ready_out   = ready_int;
  assign bus.insn_valid_out    = issue_valid;
  assign bus.insn_out          = issue_valid ? cur_word : 32'h0;
  assign bus.insn_slot_out     = issue_valid ? slot : 2'd0;
  assign bus.insn_block_id_out = issue_valid ? head_id : '0;
  assign bus.insn_last_out     = issue_valid && is_last;
  assign bus.block_done_out    = done_q;
  assign bus.block_done_id_out = done_id_q;
  assign bus.busy_out          = !empty;
endmodule

// File: tb/tb_block_issue_sequencer.sv
// tb/tb_block_issue_sequencer.sv - directed self-checking bench for block_issue_sequencer
module tb_block_issue_sequencer;
  localparam int ID_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  block_issue_sequencer_if #(.ID_W(ID_W)) bus ();

  block_issue_sequencer #(.ID_W(ID_W), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] w(input int id, input int s);
    return 32'h0A00_0000 + 32'(id) * 32'h100 + 32'(s) + 32'h1;
  endfunction

  function automatic logic [127:0] blk(input int id);
    return {w(id, 0), w(id, 1), w(id, 2), w(id, 3)};
  endfunction

  task automatic expect_issue(input string tag, input logic [31:0] word, input int slot,
                              input int id, input bit last);
    check_val({tag, "_valid"}, 128'(bus.insn_valid_out), 128'(1));
    check_val({tag, "_insn"},  128'(bus.insn_out), 128'(word));
    check_val({tag, "_slot"},  128'(bus.insn_slot_out), 128'(slot));
    check_val({tag, "_id"},    128'(bus.insn_block_id_out), 128'(id));
    check_val({tag, "_last"},  128'(bus.insn_last_out), 128'(last));
    tick();
  endtask

  task automatic chk_reset(input string tag);
    check_val({tag, "_valid"},   128'(bus.insn_valid_out), 128'(0));
    check_val({tag, "_insn"},    128'(bus.insn_out), 128'(0));
    check_val({tag, "_slot"},    128'(bus.insn_slot_out), 128'(0));
    check_val({tag, "_id"},      128'(bus.insn_block_id_out), 128'(0));
    check_val({tag, "_last"},    128'(bus.insn_last_out), 128'(0));
    check_val({tag, "_done"},    128'(bus.block_done_out), 128'(0));
    check_val({tag, "_done_id"}, 128'(bus.block_done_id_out), 128'(0));
    check_val({tag, "_busy"},    128'(bus.busy_out), 128'(0));
    check_val({tag, "_ready"},   128'(bus.block_ready_out), 128'(1));
  endtask

  initial begin
    logic [31:0] basic [4];
    bit   [3:0]  pat;
    int          k, acc, id, took;

    basic[0] = 32'h00500513; basic[1] = 32'h00520293;
    basic[2] = 32'h00600593; basic[3] = 32'h00628313;
    pat = 4'b1001;

    bus.block_data_in  = '0;
    bus.block_id_in    = '0;
    bus.block_valid_in = 1'b0;
    bus.flush_in       = 1'b0;
    bus.insn_ready_in  = 1'b1;

    tick();
    chk_reset("rst0");
    rst = 1'b0;

    // Basic issue
    bus.block_data_in  = {basic[0], basic[1], basic[2], basic[3]};
    bus.block_id_in    = 7'h01;
    bus.block_valid_in = 1'b1;
    check_val("basic_ready", 128'(bus.block_ready_out), 128'(1));
    tick();
    bus.block_valid_in = 1'b0;
    for (int s = 0; s < 4; s++) expect_issue("basic", basic[s], s, 1, s == 3);
    check_val("basic_after_valid", 128'(bus.insn_valid_out), 128'(0));
    check_val("basic_done",        128'(bus.block_done_out), 128'(1));
    check_val("basic_done_id",     128'(bus.block_done_id_out), 128'(1));
    check_val("basic_busy",        128'(bus.busy_out), 128'(0));
    tick();
    check_val("basic_done_fall",   128'(bus.block_done_out), 128'(0));

    // Padding skip, then an all-zero block
    bus.block_data_in  = {basic[0], 32'h0, 32'h0, basic[3]};
    bus.block_id_in    = 7'h02;
    bus.block_valid_in = 1'b1;
    tick();
    bus.block_valid_in = 1'b0;
    expect_issue("pad0", basic[0], 0, 2, 1'b0);
    expect_issue("pad3", basic[3], 3, 2, 1'b1);
    check_val("pad_done_id", 128'(bus.block_done_id_out), 128'(2));
    bus.block_data_in  = '0;
    bus.block_id_in    = 7'h05;
    bus.block_valid_in = 1'b1;
    tick();
    bus.block_valid_in = 1'b0;
    check_val("zero_no_issue", 128'(bus.insn_valid_out), 128'(0));
    check_val("zero_busy",     128'(bus.busy_out), 128'(1));
    tick();
    check_val("zero_done",     128'(bus.block_done_out), 128'(1));
    check_val("zero_done_id",  128'(bus.block_done_id_out), 128'(5));
    check_val("zero_idle",     128'(bus.busy_out), 128'(0));
    tick();

    // Back-pressure with ready pattern 1,0,0,1
    bus.block_data_in  = blk(3);
    bus.block_id_in    = 7'h03;
    bus.block_valid_in = 1'b1;
    tick();
    bus.block_valid_in = 1'b0;
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      bus.insn_ready_in = pat[c % 4];
      check_val("bp_valid", 128'(bus.insn_valid_out), 128'(1));
      check_val("bp_insn",  128'(bus.insn_out), 128'(w(3, k)));
      check_val("bp_slot",  128'(bus.insn_slot_out), 128'(k));
      if (bus.insn_ready_in) k++;
      tick();
    end
    check_val("bp_all_slots", 128'(k), 128'(4));
    check_val("bp_done_id",   128'(bus.block_done_id_out), 128'(3));
    check_val("bp_done",      128'(bus.block_done_out), 128'(1));
    bus.insn_ready_in = 1'b1;
    tick();

    // Full FIFO: IDs 1 and 2 fill it, ID 3 waits for ID 1 to retire
    bus.insn_ready_in  = 1'b0;
    bus.block_data_in  = blk(1);
    bus.block_id_in    = 7'h01;
    bus.block_valid_in = 1'b1;
    tick();
    bus.block_data_in  = blk(2);
    bus.block_id_in    = 7'h02;
    check_val("full_ready_one", 128'(bus.block_ready_out), 128'(1));
    tick();
    bus.block_data_in  = blk(3);
    bus.block_id_in    = 7'h03;
    check_val("full_ready_drop", 128'(bus.block_ready_out), 128'(0));
    check_val("full_stall_slot", 128'(bus.insn_slot_out), 128'(0));
    check_val("full_stall_id",   128'(bus.insn_block_id_out), 128'(1));
    tick();
    check_val("full_still_wait", 128'(bus.block_ready_out), 128'(0));
    bus.insn_ready_in = 1'b1;
    acc = -1;
    for (int c = 0; c < 12; c++) begin
      id = c / 4 + 1;
      check_val("full_valid", 128'(bus.insn_valid_out), 128'(1));
      check_val("full_id",    128'(bus.insn_block_id_out), 128'(id));
      check_val("full_slot",  128'(bus.insn_slot_out), 128'(c % 4));
      check_val("full_insn",  128'(bus.insn_out), 128'(w(id, c % 4)));
      if (c == 4 || c == 8) begin
        check_val("full_done",    128'(bus.block_done_out), 128'(1));
        check_val("full_done_id", 128'(bus.block_done_id_out), 128'(id - 1));
      end
      took = int'(bus.block_valid_in && bus.block_ready_out);
      if (took != 0) acc = c;
      tick();
      if (took != 0) bus.block_valid_in = 1'b0;
    end
    check_val("full_accept_cycle", 128'(acc), 128'(4));
    check_val("full_last_done_id", 128'(bus.block_done_id_out), 128'(3));
    check_val("full_drained",      128'(bus.busy_out), 128'(0));
    tick();

    // Flush mid-block with ID 2 buffered and a push presented
    bus.block_data_in  = blk(1);
    bus.block_id_in    = 7'h01;
    bus.block_valid_in = 1'b1;
    tick();
    bus.block_data_in  = blk(2);
    bus.block_id_in    = 7'h02;
    expect_issue("fl_s0", w(1, 0), 0, 1, 1'b0);
    bus.block_valid_in = 1'b0;
    expect_issue("fl_s1", w(1, 1), 1, 1, 1'b0);
    bus.flush_in       = 1'b1;
    bus.insn_ready_in  = 1'b0;
    bus.block_data_in  = blk(9);
    bus.block_id_in    = 7'h09;
    bus.block_valid_in = 1'b1;
    #1;
    check_val("fl_ready_low", 128'(bus.block_ready_out), 128'(0));
    tick();
    bus.flush_in       = 1'b0;
    bus.block_valid_in = 1'b0;
    bus.insn_ready_in  = 1'b1;
    check_val("fl_no_issue", 128'(bus.insn_valid_out), 128'(0));
    check_val("fl_no_done",  128'(bus.block_done_out), 128'(0));
    check_val("fl_empty",    128'(bus.busy_out), 128'(0));
    tick();
    check_val("fl_no_push",  128'(bus.busy_out), 128'(0));
    check_val("fl_still_idle", 128'(bus.insn_valid_out), 128'(0));
    bus.block_data_in  = blk(4);
    bus.block_id_in    = 7'h04;
    bus.block_valid_in = 1'b1;
    tick();
    bus.block_valid_in = 1'b0;
    for (int s = 0; s < 4; s++) expect_issue("fl_next", w(4, s), s, 4, s == 3);
    check_val("fl_next_done_id", 128'(bus.block_done_id_out), 128'(4));
    tick();

    // Reset mid-block
    bus.block_data_in  = blk(6);
    bus.block_id_in    = 7'h06;
    bus.block_valid_in = 1'b1;
    tick();
    bus.block_valid_in = 1'b0;
    expect_issue("rs_s0", w(6, 0), 0, 6, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_mid");
    tick();
    check_val("rst_no_stale", 128'(bus.insn_valid_out), 128'(0));
    check_val("rst_idle",     128'(bus.busy_out), 128'(0));
    tick();
    check_val("rst_no_stale2", 128'(bus.insn_valid_out), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/block_issue_sequencer.md
# block_issue_sequencer

Sits between the 128-bit instruction-block input of `soc_top` and the expander/decode pipeline. It buffers incoming 4-instruction blocks tagged with a block ID and issues them one 32-bit instruction per cycle in program order over a valid/ready handshake. All-zero padding slots are skipped, and a completion pulse is emitted per block. It is the single point that sequences the block stream into the datapath and applies back-pressure to the block source.

## Interface
- `ID_W`, 7, width of block ID
- `DEPTH`, 2, block buffer entries (power of 2, ≥2)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `block_data_in`  in  128  four instructions; slot 0 = [127:96] (first in program order), slot 3 = [31:0]
- `block_id_in`  in  ID_W  tag for the presented block
- `block_valid_in`  in  1  block present
- `block_ready_out`  out  1  block accepted this cycle if valid and ready
- `flush_in`  in  1  discard all buffered and in-flight state
- `insn_out`  out  32  current instruction
- `insn_valid_out`  out  1  instruction valid
- `insn_ready_in`  in  1  downstream accepts instruction
- `insn_block_id_out`  out  ID_W  ID of the issuing block
- `insn_slot_out`  out  2  slot index (0..3) of `insn_out`
- `insn_last_out`  out  1  no further non-padding slot in this block
- `block_done_out`  out  1  one-cycle pulse when a block retires
- `block_done_id_out`  out  ID_W  ID of retired block, valid with pulse
- `busy_out`  out  1  buffer non-empty

## Operation
- Buffer: circular FIFO of DEPTH entries {data, id, 4-bit live mask}. On push, live mask bit k = (slot k word != 32'h0).
- Push when `block_valid_in && block_ready_out`. `block_ready_out = !full && !flush_in`. There is no pass-through when full, even when a pop occurs the same cycle.
- States: IDLE (FIFO empty) and ISSUE (head present).
  - IDLE→ISSUE on push.
  - ISSUE→IDLE when the head retires and the FIFO holds no other entry and no push occurs.
- In ISSUE, the slot pointer selects the lowest set bit of the head live mask. `insn_valid_out = 1`, and `insn_out`, `insn_slot_out` and `insn_block_id_out` come from the head entry.
- On `insn_valid_out && insn_ready_in`, clear the current live bit. If it was the last set bit (`insn_last_out`), the head retires:
  - pop;
  - `block_done_out` pulses next cycle with that ID.
- Empty-mask block (all four words zero): retires the cycle after it becomes head, with no issue and `insn_valid_out = 0`. `block_done_out` still pulses.
- Outputs must hold stable while `insn_valid_out && !insn_ready_in`.
- Flush: all FIFO entries and live masks are invalidated at the next edge. Any `block_done_out` pulse is suppressed. No push occurs in the flush cycle.
- Priority: rst > flush_in > pop/push.
- Pointer wrap: the read and write pointers are `log2(DEPTH)` bits plus a wrap bit. Full = indices equal and wrap bits differ.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `insn_valid_out = 0`, `insn_out = 0`, `insn_slot_out = 0`, `insn_block_id_out = 0`, `insn_last_out = 0`
  - `block_done_out = 0`, `block_done_id_out = 0`, `busy_out = 0`
  - `block_ready_out = 1`
  - FIFO empty, state IDLE
- Latency: a block pushed at edge N gives `insn_valid_out` high in cycle N+1 (after that edge).
- Throughput: 1 instruction/cycle with `insn_ready_in` held high. There is no bubble between the last slot of one block and the first slot of the next.
- `block_done_out`: registered, one cycle after the retiring handshake edge.
- `rst` or `flush_in` asserted mid-block: the block is dropped with no further issue. After flush, `insn_valid_out = 0` from the next cycle.

## Test plan
- Basic issue: push {00500513, 00520293, 00600593, 00628313}, ID 7'h01, ready held high -> four consecutive cycles with slots 0..3 and those words in that order; `insn_last_out` high only on 00628313; `block_done_out` with ID 01 one cycle later; `busy_out` falls.
- Padding skip: push {00500513, 0, 0, 00628313} -> two issues, slots 0 and 3, last on slot 3. Push an all-zero block with ID 7'h05 -> no issue, done pulse with ID 05.
- Back-pressure: toggle `insn_ready_in` 1,0,0,1,… -> `insn_out` is stable while stalled, no slot is duplicated or lost, and order is preserved.
- Full FIFO: DEPTH=2, stall downstream and push IDs 1, 2, 3 -> `block_ready_out` drops after the 2nd push, so ID 3 waits. After ID 1 retires, ID 3 is accepted, and issue order is 1, 2, 3 back-to-back with no bubble.
- Flush mid-block: flush after slot 1 of ID 1 while ID 2 is buffered and a push is presented -> no issue next cycle, no done pulse, and the push is not taken. The next block issues normally from slot 0.
- Reset mid-operation: assert `rst` for one cycle during issue -> all outputs take their reset values next cycle and no stale instruction appears afterwards.
